// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared constants, state encoding and helpers for the fetch stage
// Contents:
//   XLEN                      - datapath width
//   RESET_PC_DEF/NOP_INST_DEF - default reset fetch address and bubble instruction
//   fetch_state_e             - fetch FSM states (IDLE, BUSY, HOLD)
//   pc_plus4()                - sequential PC, wraps modulo 2^XLEN
package if_fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble controls
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   load, load_inst/pc     - capture a live instruction and its PC (PC+4 derived here)
//   bubble                 - invalidate and insert NOP_INST, PC fields kept
//   valid, inst, pc, pc4   - register contents presented to decode
// Neither load nor bubble means hold.
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
            pc4   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
            pc4   <= pc_plus4(load_pc);
        end else if (bubble) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC, single-outstanding imem handshake and IF/ID register
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   npc_i                    - next PC from the next-PC unit
//   stall_i, flush_i         - decode backpressure, taken-branch redirect
//   pc_o                     - current fetch PC
//   imem_req_o/addr_o        - request level and address (held until response)
//   imem_rvalid_i/rdata_i    - one-cycle response strobe and instruction word
//   if_id_valid/inst/pc/pc4  - IF/ID register contents for decode
// Optional: define IF_FETCH_PERF_EN to add perf_fetch_cnt_o and perf_bubble_cnt_o.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] npc_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] pc_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_inst_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_bubble_cnt_o
`endif
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            discard, discard_n;
    logic [XLEN-1:0] hb_inst, hb_inst_n, hb_pc, hb_pc_n;
    logic            ld, bub;
    logic [XLEN-1:0] ld_inst, ld_pc;

    assign pc_o        = pc;
    assign imem_req_o  = state == BUSY;
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            discard <= 1'b0;
            hb_inst <= '0;
            hb_pc   <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            discard <= discard_n;
            hb_inst <= hb_inst_n;
            hb_pc   <= hb_pc_n;
        end
    end

    // Flush wins over everything; a response still owed for the killed
    // request is marked for discard so it never reaches IF/ID.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        discard_n = discard;
        hb_inst_n = hb_inst;
        hb_pc_n   = hb_pc;
        ld        = 1'b0;
        bub       = 1'b0;
        ld_inst   = imem_rdata_i;
        ld_pc     = pc;
        case (state)
            IDLE: state_n = BUSY;
            BUSY: begin
                if (flush_i) begin
                    pc_n      = npc_i;
                    bub       = 1'b1;
                    discard_n = ~imem_rvalid_i;
                    hb_inst_n = '0;
                    hb_pc_n   = '0;
                end else if (imem_rvalid_i && discard) begin
                    discard_n = 1'b0;
                    bub       = ~stall_i;
                end else if (imem_rvalid_i && !stall_i) begin
                    ld   = 1'b1;
                    pc_n = npc_i;
                end else if (imem_rvalid_i) begin
                    hb_inst_n = imem_rdata_i;
                    hb_pc_n   = pc;
                    state_n   = HOLD;
                end else begin
                    bub = ~stall_i;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pc_n      = npc_i;
                    bub       = 1'b1;
                    hb_inst_n = '0;
                    hb_pc_n   = '0;
                    state_n   = BUSY;
                end else if (!stall_i) begin
                    ld      = 1'b1;
                    ld_inst = hb_inst;
                    ld_pc   = hb_pc;
                    pc_n    = npc_i;
                    state_n = BUSY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .bubble   (bub),
        .load_inst(ld_inst),
        .load_pc  (ld_pc),
        .valid    (if_id_valid_o),
        .inst     (if_id_inst_o),
        .pc       (if_id_pc_o),
        .pc4      (if_id_pc4_o)
    );

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_o  <= '0;
            perf_bubble_cnt_o <= '0;
        end else begin
            perf_fetch_cnt_o  <= perf_fetch_cnt_o + 32'(ld);
            perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'(bub);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for if_fetch_stage using directed vectors
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc_i;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] redirect = '0;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_id_valid_o;
    logic [31:0] if_id_inst_o, if_id_pc_o, if_id_pc4_o;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o, perf_bubble_cnt_o;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    assign npc_i = flush_i ? redirect : pc_o + 32'd4;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .npc_i        (npc_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .pc_o         (pc_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_id_valid_o(if_id_valid_o),
        .if_id_inst_o (if_id_inst_o),
        .if_id_pc_o   (if_id_pc_o),
        .if_id_pc4_o  (if_id_pc4_o)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_bubble_cnt_o(perf_bubble_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic rv, input logic [31:0] rd);
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        @(posedge clk);
        #1;
        imem_rvalid_i = 1'b0;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pc4);
        q.push_back('{inst: inst, pc: pc, pc4: pc4});
    endtask

    // Decode consumes IF/ID whenever it is live and neither stalled nor flushed.
    always @(negedge clk) begin
        if (!rst && !flush_i && !stall_i && if_id_valid_o) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL ifid_unexpected: got inst %h pc %h with nothing expected",
                         if_id_inst_o, if_id_pc_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({if_id_inst_o, if_id_pc_o, if_id_pc4_o} !== e) begin
                    n_bad++;
                    $display("FAIL ifid: got inst %h pc %h pc4 %h expected inst %h pc %h pc4 %h",
                             if_id_inst_o, if_id_pc_o, if_id_pc4_o, e.inst, e.pc, e.pc4);
                end
            end
        end
    end

    initial begin
        tick(0, '0);
        tick(0, '0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_valid", 32'(if_id_valid_o), 32'h0);
        chk("rst_inst", if_id_inst_o, 32'h13);
        chk("rst_ifpc", if_id_pc_o, 32'h0);
        chk("rst_ifpc4", if_id_pc4_o, 32'h0);
        rst = 1'b0;
        tick(0, '0);
        chk("req0", 32'(imem_req_o), 32'h1);
        chk("addr0", imem_addr_o, 32'h0);
        tick(0, '0);
        push(32'h0000_1111, 32'h0, 32'h4);
        tick(1, 32'h0000_1111);
        chk("pc_after0", pc_o, 32'h4);
        tick(0, '0);
        chk("addr1", imem_addr_o, 32'h4);
        push(32'h0000_2222, 32'h4, 32'h8);
        tick(1, 32'h0000_2222);
        tick(0, '0);
        chk("addr2", imem_addr_o, 32'h8);
        stall_i = 1'b1;
        push(32'hDEAD_BEEF, 32'h8, 32'hC);
        tick(1, 32'hDEAD_BEEF);
        chk("hold_state", 32'(dut.state), 32'(HOLD));
        chk("hold_req", 32'(imem_req_o), 32'h0);
        chk("hold_pc", pc_o, 32'h8);
        tick(0, '0);
        chk("hold_stay", 32'(dut.state), 32'(HOLD));
        stall_i = 1'b0;
        tick(0, '0);
        chk("release_pc", pc_o, 32'hC);
        chk("release_inst", if_id_inst_o, 32'hDEAD_BEEF);
        chk("release_ifpc", if_id_pc_o, 32'h8);
        tick(0, '0);
        push(32'h0000_3333, 32'hC, 32'h10);
        tick(1, 32'h0000_3333);
        tick(0, '0);
        chk("addr_10", imem_addr_o, 32'h10);
        flush_i  = 1'b1;
        redirect = 32'h100;
        tick(0, '0);
        flush_i = 1'b0;
        chk("flush_pc", pc_o, 32'h100);
        chk("flush_valid", 32'(if_id_valid_o), 32'h0);
        chk("flush_discard", 32'(dut.discard), 32'h1);
        tick(1, 32'h1111_1111);
        chk("stale_pc", pc_o, 32'h100);
        chk("stale_valid", 32'(if_id_valid_o), 32'h0);
        chk("stale_discard", 32'(dut.discard), 32'h0);
        tick(0, '0);
        push(32'h0000_4444, 32'h100, 32'h104);
        tick(1, 32'h0000_4444);
        tick(0, '0);
        flush_i  = 1'b1;
        redirect = 32'h200;
        tick(1, 32'h2222_2222);
        flush_i = 1'b0;
        chk("coflush_pc", pc_o, 32'h200);
        chk("coflush_discard", 32'(dut.discard), 32'h0);
        chk("coflush_valid", 32'(if_id_valid_o), 32'h0);
        tick(0, '0);
        push(32'h0000_5555, 32'h200, 32'h204);
        tick(1, 32'h0000_5555);
        chk("coflush_next_pc", pc_o, 32'h204);
        tick(0, '0);
        rst = 1'b1;
        tick(0, '0);
        rst = 1'b0;
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_req", 32'(imem_req_o), 32'h0);
        chk("mid_rst_ifpc", if_id_pc_o, 32'h0);
        chk("mid_rst_ifpc4", if_id_pc4_o, 32'h0);
        tick(1, 32'h3333_3333);
        chk("late_valid", 32'(if_id_valid_o), 32'h0);
        chk("late_inst", if_id_inst_o, 32'h13);
        chk("late_pc", pc_o, 32'h0);
        chk("late_req", 32'(imem_req_o), 32'h1);
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch_rst", perf_fetch_cnt_o, 32'h0);
        chk("perf_bubble_rst", perf_bubble_cnt_o, 32'h0);
`endif
        stall_i = 1'b1;
        tick(0, '0);
        stall_i = 1'b0;
        push(32'h0000_6666, 32'h0, 32'h4);
        tick(1, 32'h0000_6666);
        tick(0, '0);
        push(32'h0000_7777, 32'h4, 32'h8);
        tick(1, 32'h0000_7777);
        tick(0, '0);
        push(32'h0000_8888, 32'h8, 32'hC);
        tick(1, 32'h0000_8888);
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt_o, 32'd3);
        chk("perf_bubble", perf_bubble_cnt_o, 32'd2);
`endif
        tick(0, '0);
        tick(0, '0);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
